// File: rtl/config_adder_pkg.sv
// Shared lane-mode encoding and width helpers for the configurable adder tree.
// Encoding 2'b11 is reserved and is treated as full width everywhere.
package config_adder_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'b00,
        MODE_HALF    = 2'b01,
        MODE_QUARTER = 2'b10
    } mode_e;

    function automatic int lane_count(input logic [1:0] mode);
        case (mode)
            MODE_HALF:    return 2;
            MODE_QUARTER: return 4;
            default:      return 1;
        endcase
    endfunction

    // Quarter lanes grow one bit per layer, so the packed word grows four.
    function automatic int out_width(input int p, input int n);
        return p + 4 * $clog2(n);
    endfunction

endpackage

// File: rtl/config_adder_tree_stage.sv
// LAYERS combinational lane-wise pairwise-add layers followed by one pipeline
// register slot (data, mode, valid) with a valid/ready handshake.
module config_adder_tree_stage
    import config_adder_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int W_IN   = 8,
    parameter int LAYERS = 1,
    localparam int N_OUT = N_IN >> LAYERS,
    localparam int W_OUT = W_IN + 4 * LAYERS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [W_IN-1:0]  i_data [N_IN],
    input  logic [1:0]       i_mode,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [W_OUT-1:0] o_data [N_OUT],
    output logic [1:0]       o_mode,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int HI = W_IN / 2;
    localparam int QI = W_IN / 4;
    localparam int HO = W_OUT / 2;
    localparam int QO = W_OUT / 4;

    // Sign-extend every lane to its output-lane width up front; the widened
    // lanes can hold the sum of all inputs, so later adds never overflow.
    function automatic logic [W_OUT-1:0] f_widen(input logic [W_IN-1:0] d,
                                                 input logic [1:0] m);
        logic [W_OUT-1:0] r;
        r = '0;
        case (m)
            MODE_HALF: begin
                for (int j = 0; j < 2; j++)
                    r[j*HO +: HO] = HO'($signed(d[j*HI +: HI]));
            end
            MODE_QUARTER: begin
                for (int j = 0; j < 4; j++)
                    r[j*QO +: QO] = QO'($signed(d[j*QI +: QI]));
            end
            default: r = W_OUT'($signed(d));
        endcase
        return r;
    endfunction

    // Lane-wise add; each lane sum is truncated to its own field, so carries
    // never reach the neighbouring lane.
    function automatic logic [W_OUT-1:0] f_add(input logic [W_OUT-1:0] a,
                                               input logic [W_OUT-1:0] b,
                                               input logic [1:0] m);
        logic [W_OUT-1:0] r;
        r = '0;
        case (m)
            MODE_HALF: begin
                for (int j = 0; j < 2; j++)
                    r[j*HO +: HO] = a[j*HO +: HO] + b[j*HO +: HO];
            end
            MODE_QUARTER: begin
                for (int j = 0; j < 4; j++)
                    r[j*QO +: QO] = a[j*QO +: QO] + b[j*QO +: QO];
            end
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic [W_OUT-1:0] w_sum  [N_OUT];
    logic [W_OUT-1:0] r_data [N_OUT];
    logic [1:0]       r_mode;
    logic             r_valid;

    always_comb begin
        logic [W_OUT-1:0] w_node [N_IN];
        for (int i = 0; i < N_IN; i++)
            w_node[i] = f_widen(i_data[i], i_mode);
        for (int l = 0; l < LAYERS; l++)
            for (int i = 0; i < (N_IN >> (l + 1)); i++)
                w_node[i] = f_add(w_node[2*i], w_node[2*i+1], i_mode);
        for (int i = 0; i < N_OUT; i++)
            w_sum[i] = w_node[i];
    end

    // Slot accepts when empty or when its content leaves this cycle.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= 2'b00;
            r_data  <= '{default: '0};
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_sum;
                r_mode <= i_mode;
            end
        end
    end

    assign o_data  = r_data;
    assign o_mode  = r_mode;
    assign o_valid = r_valid;

endmodule

// File: rtl/config_adder_tree_pipelined.sv
// Pipelined multi-precision adder tree: STAGES register slots, each holding up
// to REG_EVERY adder layers, chained with a stall-propagating handshake.
module config_adder_tree_pipelined
    import config_adder_pkg::*;
#(
    parameter int INPUTS_AMOUNT = 8,
    parameter int P             = 8,
    parameter int REG_EVERY     = 1,
    localparam int LOG2N  = $clog2(INPUTS_AMOUNT),
    localparam int OUT_W  = out_width(P, INPUTS_AMOUNT),
    localparam int STAGES = (LOG2N + REG_EVERY - 1) / REG_EVERY
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [P-1:0]     data_i [INPUTS_AMOUNT],
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] sum_o,
    output logic [1:0]       mode_o,
    output logic             valid_o,
    input  logic             ready_i
);

    // Handshake: a beat moves across link k when w_valid[k] && w_ready[k].
    // Producers hold data/mode stable while valid is high and ready is low;
    // ready flows backwards combinationally, so ready_o follows ready_i.
    logic       w_valid [STAGES+1];
    logic       w_ready [STAGES+1];
    logic [1:0] w_mode  [STAGES+1];

    assign w_valid[0]      = valid_i;
    assign w_mode[0]       = mode_i;
    assign ready_o         = w_ready[0];
    assign w_ready[STAGES] = ready_i;
    assign valid_o         = w_valid[STAGES];
    assign mode_o          = w_mode[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int REM = LOG2N - s * REG_EVERY;
        localparam int LAY = (REM < REG_EVERY) ? REM : REG_EVERY;
        localparam int NI  = INPUTS_AMOUNT >> (s * REG_EVERY);
        localparam int WI  = P + 4 * s * REG_EVERY;

        logic [WI-1:0]       w_in  [NI];
        logic [WI+4*LAY-1:0] w_out [NI >> LAY];

        if (s == 0) begin : g_head
            assign w_in = data_i;
        end else begin : g_link
            for (genvar i = 0; i < NI; i++) begin : g_cp
                assign w_in[i] = g_stage[s-1].w_out[i];
            end
        end

        config_adder_tree_stage #(
            .N_IN   (NI),
            .W_IN   (WI),
            .LAYERS (LAY)
        ) u_stage (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_data  (w_in),
            .i_mode  (w_mode[s]),
            .i_valid (w_valid[s]),
            .o_ready (w_ready[s]),
            .o_data  (w_out),
            .o_mode  (w_mode[s+1]),
            .o_valid (w_valid[s+1]),
            .i_ready (w_ready[s+1])
        );
    end

    // The last stage already produces one word in the OUT_W lane layout.
    assign sum_o = g_stage[STAGES-1].w_out[0];

endmodule
